// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic-array result collector.
package sys_array_pkg;

    typedef enum logic {C_IDLE, C_RUN} cap_state_t;
    typedef enum logic {D_IDLE, D_OUT} drn_state_t;

    function automatic int capture_len(input int array_w);
        return 2 * array_w - 1;
    endfunction

    function automatic int elem_w(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int row_aw(input int array_w);
        return (array_w > 1) ? $clog2(array_w) : 1;
    endfunction

endpackage

// File: rtl/sys_array_result_collector_if.sv
// Capture input and row-beat output bundle of the result collector.
interface sys_array_result_collector_if
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 4
);
    localparam int BW = elem_w(DATA_WIDTH) * ARRAY_W;

    logic          capture_start;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [15:0]   out_row;
    logic          out_last;
    logic          busy;
    logic          overrun;

    modport master (
        output capture_start, in_data, out_ready,
        input  out_valid, out_data, out_row, out_last, busy, overrun
    );

    modport slave (
        input  capture_start, in_data, out_ready,
        output out_valid, out_data, out_row, out_last, busy, overrun
    );

endinterface

// File: rtl/sys_array_result_bank.sv
// One ARRAY_W x ARRAY_W result bank: each column writes its own row address, rows read combinationally.
module sys_array_result_bank
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 4,
    parameter int RW         = 2
)
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic [ARRAY_W-1:0]              i_we,
    input  logic [ARRAY_W-1:0][RW-1:0]      i_waddr,
    input  logic [elem_w(DATA_WIDTH)*ARRAY_W-1:0] i_wdata,
    input  logic [RW-1:0]                   i_raddr,
    output logic [elem_w(DATA_WIDTH)*ARRAY_W-1:0] o_rdata
);
    localparam int EW = elem_w(DATA_WIDTH);

    logic [EW-1:0] r_mem [ARRAY_W][ARRAY_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ARRAY_W; r++)
                for (int c = 0; c < ARRAY_W; c++)
                    r_mem[r][c] <= '0;
        end else begin
            for (int c = 0; c < ARRAY_W; c++)
                if (i_we[c])
                    r_mem[i_waddr[c]][c] <= i_wdata[EW*c +: EW];
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int c = 0; c < ARRAY_W; c++)
            o_rdata[EW*c +: EW] = r_mem[i_raddr][c];
    end

endmodule

// File: rtl/sys_array_result_collector.sv
// De-skews the array bottom-edge stream into a matrix and drains it row by row.
// SYS_ARRAY_COLLECT_DBUF_EN selects two ping-pong banks instead of one.
module sys_array_result_collector
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 4
)
(
    input  logic                       clock,
    input  logic                       reset,
    sys_array_result_collector_if.slave bus
);
    localparam int EW          = elem_w(DATA_WIDTH);
    localparam int BW          = EW * ARRAY_W;
    localparam int CAPTURE_LEN = capture_len(ARRAY_W);
    localparam int RW          = row_aw(ARRAY_W);
`ifdef SYS_ARRAY_COLLECT_DBUF_EN
    localparam bit DBUF  = 1'b1;
    localparam int NBANK = 2;
`else
    localparam bit DBUF  = 1'b0;
    localparam int NBANK = 1;
`endif

    cap_state_t r_cap_state, w_cap_state_nxt;
    drn_state_t r_drn_state, w_drn_state_nxt;
    logic [15:0]   r_t, w_t_nxt, w_t;
    logic          r_cap_ptr, w_cap_ptr_nxt;
    logic          r_drn_ptr, w_drn_ptr_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [1:0]    r_full, w_full_nxt;
    logic          r_overrun, w_overrun_nxt;

    logic w_valid, w_hs, w_row_last, w_free_now, w_tgt_free, w_accept;
    logic w_cap_done, w_cap_active, w_other, w_other_full;
    logic [ARRAY_W-1:0]               w_we;
    logic [ARRAY_W-1:0][RW-1:0]       w_waddr;
    logic [NBANK-1:0][ARRAY_W-1:0]    w_bank_we;
    logic [NBANK-1:0][BW-1:0]         w_rdata;
    logic [BW-1:0]                    w_rd_sel;

    assign w_valid      = (r_drn_state == D_OUT);
    assign w_hs         = w_valid & bus.out_ready;
    assign w_row_last   = (r_row == RW'(ARRAY_W - 1));
    assign w_free_now   = w_hs & w_row_last;
    // A bank released by this cycle's final handshake is already usable for a new capture.
    assign w_tgt_free   = ~r_full[r_cap_ptr] | (w_free_now & (r_drn_ptr == r_cap_ptr));
    assign w_accept     = bus.capture_start & (r_cap_state == C_IDLE) & w_tgt_free;
    assign w_cap_done   = (r_cap_state == C_RUN) & (r_t == 16'(CAPTURE_LEN - 1));
    assign w_cap_active = w_accept | (r_cap_state == C_RUN);
    assign w_t          = (r_cap_state == C_RUN) ? r_t : 16'd0;
    assign w_other      = r_drn_ptr ^ DBUF;
    assign w_other_full = DBUF & (r_full[w_other] | (w_cap_done & (r_cap_ptr == w_other)));

    for (genvar c = 0; c < ARRAY_W; c++) begin : g_col
        assign w_we[c]    = w_cap_active & (w_t >= 16'(c)) & (w_t <= 16'(c + ARRAY_W - 1));
        assign w_waddr[c] = RW'(w_t - 16'(c));
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign w_bank_we[b] = w_we & {ARRAY_W{r_cap_ptr == 1'(b)}};
        sys_array_result_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ARRAY_W    (ARRAY_W),
            .RW         (RW)
        ) u_bank (
            .clock   (clock),
            .reset   (reset),
            .i_we    (w_bank_we[b]),
            .i_waddr (w_waddr),
            .i_wdata (bus.in_data),
            .i_raddr (r_row),
            .o_rdata (w_rdata[b])
        );
    end

    assign w_rd_sel = (r_drn_ptr && NBANK > 1) ? w_rdata[NBANK-1] : w_rdata[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cap_state <= C_IDLE;
            r_drn_state <= D_IDLE;
            r_t         <= '0;
            r_cap_ptr   <= 1'b0;
            r_drn_ptr   <= 1'b0;
            r_row       <= '0;
            r_full      <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_cap_state <= w_cap_state_nxt;
            r_drn_state <= w_drn_state_nxt;
            r_t         <= w_t_nxt;
            r_cap_ptr   <= w_cap_ptr_nxt;
            r_drn_ptr   <= w_drn_ptr_nxt;
            r_row       <= w_row_nxt;
            r_full      <= w_full_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_cap_state_nxt = r_cap_state;
        w_drn_state_nxt = r_drn_state;
        w_t_nxt         = r_t;
        w_cap_ptr_nxt   = r_cap_ptr;
        w_drn_ptr_nxt   = r_drn_ptr;
        w_row_nxt       = r_row;
        w_full_nxt      = r_full;
        w_overrun_nxt   = bus.capture_start & ~w_accept;

        case (r_cap_state)
            C_IDLE: if (w_accept) begin
                w_cap_state_nxt = C_RUN;
                w_t_nxt         = 16'd1;
            end
            C_RUN: if (w_cap_done) begin
                w_cap_state_nxt = C_IDLE;
                w_t_nxt         = 16'd0;
                w_cap_ptr_nxt   = r_cap_ptr ^ DBUF;
            end else begin
                w_t_nxt = r_t + 16'd1;
            end
        endcase

        // Look ahead at the completing capture so the first row is valid right after the last capture cycle.
        case (r_drn_state)
            D_IDLE: if (r_full[r_drn_ptr] | (w_cap_done & (r_cap_ptr == r_drn_ptr))) begin
                w_drn_state_nxt = D_OUT;
                w_row_nxt       = '0;
            end
            D_OUT: if (w_hs) begin
                if (w_row_last) begin
                    w_row_nxt     = '0;
                    w_drn_ptr_nxt = w_other;
                    if (!w_other_full)
                        w_drn_state_nxt = D_IDLE;
                end else begin
                    w_row_nxt = r_row + RW'(1);
                end
            end
        endcase

        if (w_free_now)
            w_full_nxt[r_drn_ptr] = 1'b0;
        if (w_cap_done)
            w_full_nxt[r_cap_ptr] = 1'b1;
    end

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_rd_sel : '0;
    assign bus.out_row   = w_valid ? 16'(r_row) : 16'd0;
    assign bus.out_last  = w_valid & w_row_last;
    assign bus.busy      = (r_cap_state != C_IDLE) | (|r_full);
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_sys_array_result_collector.sv
// Randomized bench for sys_array_result_collector against a queue-of-matrices reference model.
module tb_sys_array_result_collector;
    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int EW   = 2 * DW;
    localparam int BW   = EW * W;
    localparam int CLEN = 2 * W - 1;
`ifdef SYS_ARRAY_COLLECT_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [W-1:0][W-1:0][EW-1:0] mat_t;

    logic clock = 1'b0;
    logic reset;

    sys_array_result_collector_if #(.DATA_WIDTH(DW), .ARRAY_W(W)) bus ();

    sys_array_result_collector #(.DATA_WIDTH(DW), .ARRAY_W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: matrices waiting/draining in order, plus the one being captured.
    mat_t q_mat[$];
    int   drow    = 0;
    bit   cap_on  = 1'b0;
    int   cap_t   = 0;
    mat_t cap_mat;
    bit   exp_ovr = 1'b0;
    int   cyc     = 0;
    int   first_v = -1;
    int   last_b  = -1;

    function automatic logic [BW-1:0] row_of(input mat_t m, input int r);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < W; c++) v[EW*c +: EW] = m[r][c];
        return v;
    endfunction

    function automatic mat_t pat_mat();
        mat_t m;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                m[r][c] = EW'(256 * r + c);
        return m;
    endfunction

    function automatic mat_t rnd_mat();
        mat_t m;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                m[r][c] = EW'($urandom);
        return m;
    endfunction

    task automatic step(input bit cs, input bit rdy, input mat_t m, input bit garb_ff);
        bit hs_last, acc;
        int t;
        logic [BW-1:0] d;
        @(posedge clock);
        #1;
        hs_last = (q_mat.size() > 0) && rdy && (drow == W - 1);
        acc = cs && !cap_on && ((q_mat.size() < NB) || (q_mat.size() == NB && hs_last));
        t = cap_on ? cap_t : (acc ? 0 : -1);
        for (int c = 0; c < W; c++) begin
            if (t >= c && t <= c + W - 1)
                d[EW*c +: EW] = cap_on ? cap_mat[t-c][c] : m[t-c][c];
            else
                d[EW*c +: EW] = garb_ff ? EW'(16'hFFFF) : EW'($urandom);
        end
        bus.capture_start = cs;
        bus.out_ready     = rdy;
        bus.in_data       = d;
        @(negedge clock);
        check("out_valid", BW'(bus.out_valid), BW'(q_mat.size() > 0));
        check("busy", BW'(bus.busy), BW'(cap_on || q_mat.size() > 0));
        check("overrun", BW'(bus.overrun), BW'(exp_ovr));
        if (q_mat.size() > 0) begin
            check("out_data", bus.out_data, row_of(q_mat[0], drow));
            check("out_row", BW'(bus.out_row), BW'(drow));
            check("out_last", BW'(bus.out_last), BW'(drow == W - 1));
        end
        if (bus.out_valid && first_v < 0) first_v = cyc;
        if (bus.out_valid && bus.out_last && rdy) last_b = cyc;

        exp_ovr = cs && !acc;
        if (q_mat.size() > 0 && rdy) begin
            if (drow == W - 1) begin
                void'(q_mat.pop_front());
                drow = 0;
            end else begin
                drow++;
            end
        end
        if (cap_on) begin
            if (cap_t == CLEN - 1) begin
                q_mat.push_back(cap_mat);
                cap_on = 1'b0;
            end else begin
                cap_t++;
            end
        end else if (acc) begin
            cap_on  = 1'b1;
            cap_t   = 1;
            cap_mat = m;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, '0, 1'b1);
    endtask

    task automatic mid_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.capture_start = 1'b0;
        #1;
        check("rst_out_valid", BW'(bus.out_valid), '0);
        check("rst_busy", BW'(bus.busy), '0);
        check("rst_out_last", BW'(bus.out_last), '0);
        check("rst_overrun", BW'(bus.overrun), '0);
        q_mat.delete();
        drow    = 0;
        cap_on  = 1'b0;
        exp_ovr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.capture_start = 1'b0;
        bus.out_ready     = 1'b0;
        bus.in_data       = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid", BW'(bus.out_valid), '0);
        check("reset_out_data", bus.out_data, '0);
        check("reset_out_row", BW'(bus.out_row), '0);
        check("reset_out_last", BW'(bus.out_last), '0);
        check("reset_busy", BW'(bus.busy), '0);
        check("reset_overrun", BW'(bus.overrun), '0);
        reset = 1'b0;

        // Single matrix, ready held high; check beat timing.
        cyc = 0; first_v = -1; last_b = -1;
        step(1'b1, 1'b1, pat_mat(), 1'b1);
        idle(12, 1'b1);
        check("first_valid_cycle", BW'(first_v), BW'(CLEN));
        check("last_beat_cycle", BW'(last_b), BW'(CLEN + W - 1));

        // Backpressure 1010...
        step(1'b1, 1'b1, pat_mat(), 1'b1);
        for (int i = 1; i < 24; i++) step(1'b0, (i % 2) == 0, '0, 1'b1);
        idle(4, 1'b1);

        // Second capture_start mid-capture.
        step(1'b1, 1'b1, pat_mat(), 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b1, rnd_mat(), 1'b1);
        idle(12, 1'b1);

        // Second capture_start at cycle 8 while output stalled.
        step(1'b1, 1'b0, pat_mat(), 1'b1);
        idle(7, 1'b0);
        step(1'b1, 1'b0, rnd_mat(), 1'b1);
        idle(8, 1'b0);
        idle(16, 1'b1);

        // Reset at cycle 8, then a fresh capture.
        step(1'b1, 1'b0, pat_mat(), 1'b1);
        idle(7, 1'b0);
        mid_reset();
        step(1'b1, 1'b1, rnd_mat(), 1'b1);
        idle(12, 1'b1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0)
                mid_reset();
            else
                step($urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0, rnd_mat(), 1'b0);
        end
        idle(24, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
